// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bundle for if_fetch_unit.
// master = fetch unit, slave = instruction memory.
interface if_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: credit-limited pipelined imem requests, in-order prefetch FIFO, redirect flush.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_stall_flag,
    input  logic                   ex_take_branch,
    input  logic [31:0]            ex_target_pc,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            if_id_IR,
    output logic [31:0]            if_id_PC,
    output logic                   if_id_valid_inst,
    output logic [31:0]            fetch_stall_cycles_out,
    output logic [31:0]            fetch_flush_count_out
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic [31:0]      fetch_pc;
    logic [31:0]      ir_mem  [FIFO_DEPTH];
    logic [31:0]      pc_mem  [FIFO_DEPTH];
    logic [31:0]      tag_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr, tag_rd, tag_wr;
    logic [CNT_W-1:0] count, outstanding, drop_cnt;
    logic [CNT_W:0]   credit_used;
    logic             head_valid, req_valid, req_fire, rsp_fire, discard, push, pop;
    logic             unused_target_lsbs;

    assign unused_target_lsbs = ^ex_target_pc[1:0];

    always_comb begin
        head_valid  = (count != '0);
        credit_used = {1'b0, count} + {1'b0, outstanding};
        req_valid   = !rst && !ex_take_branch && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
        req_fire    = req_valid && imem.imem_req_ready;
        rsp_fire    = !rst && imem.imem_rsp_valid;
        // A response landing in the redirect cycle belongs to the old stream.
        discard     = rsp_fire && ((drop_cnt != '0) || ex_take_branch);
        push        = rsp_fire && !discard;
        pop         = head_valid && !id_stall_flag && !ex_take_branch;
        if_id_valid_inst = head_valid;
        if_id_IR    = head_valid ? ir_mem[rd_ptr] : NOP;
        if_id_PC    = head_valid ? pc_mem[rd_ptr] : 32'h0;
    end

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_addr      = fetch_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            if (ex_take_branch)
                fetch_pc <= {ex_target_pc[31:2], 2'b00};
            else if (req_fire)
                fetch_pc <= fetch_pc + 32'd4;

            if (req_fire)
                tag_wr <= tag_wr + 1'b1;
            if (rsp_fire)
                tag_rd <= tag_rd + 1'b1;

            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_fire);

            if (ex_take_branch)
                drop_cnt <= outstanding - CNT_W'(rsp_fire);
            else if (rsp_fire && (drop_cnt != '0))
                drop_cnt <= drop_cnt - 1'b1;

            if (ex_take_branch) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Storage arrays need no reset: writes are already qualified by !rst.
    always_ff @(posedge clk) begin
        if (req_fire)
            tag_mem[tag_wr] <= fetch_pc;
        if (push) begin
            ir_mem[wr_ptr] <= imem.imem_rsp_data;
            pc_mem[wr_ptr] <= tag_mem[tag_rd];
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (head_valid && id_stall_flag && !ex_take_branch && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 32'd1;
            if (discard && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign fetch_stall_cycles_out = stall_cnt;
    assign fetch_flush_count_out  = flush_cnt;
`else
    assign fetch_stall_cycles_out = '0;
    assign fetch_flush_count_out  = '0;
`endif

    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (count == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit with a variable-latency in-order imem model.
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        id_stall_flag;
    logic        ex_take_branch;
    logic [31:0] ex_target_pc;
    logic [31:0] if_id_IR;
    logic [31:0] if_id_PC;
    logic        if_id_valid_inst;
    logic [31:0] fetch_stall_cycles_out;
    logic [31:0] fetch_flush_count_out;

    int checks = 0;
    int errors = 0;
    int mem_lat = 1;
    int cyc = 0;
    int last_due = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;
    req_t mem_q[$];

    if_fetch_unit_if imem_bus();

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .id_stall_flag          (id_stall_flag),
        .ex_take_branch         (ex_take_branch),
        .ex_target_pc           (ex_target_pc),
        .imem                   (imem_bus),
        .if_id_IR               (if_id_IR),
        .if_id_PC               (if_id_PC),
        .if_id_valid_inst       (if_id_valid_inst),
        .fetch_stall_cycles_out (fetch_stall_cycles_out),
        .fetch_flush_count_out  (fetch_flush_count_out)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A00_0013;
    endfunction

    // imem model: accepts at negedge, answers in order after mem_lat cycles
    initial begin
        imem_bus.imem_rsp_valid = 1'b0;
        imem_bus.imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            imem_bus.imem_rsp_valid = 1'b0;
            if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
                imem_bus.imem_rsp_valid = 1'b1;
                imem_bus.imem_rsp_data  = instr_of(mem_q[0].addr);
                void'(mem_q.pop_front());
            end
            @(negedge clk);
            if (rst) begin
                mem_q.delete();
            end else if (imem_bus.imem_req_valid && imem_bus.imem_req_ready) begin
                req_t r;
                r.addr = imem_bus.imem_addr;
                r.due  = (cyc + mem_lat > last_due + 1) ? cyc + mem_lat : last_due + 1;
                last_due = r.due;
                mem_q.push_back(r);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        id_stall_flag = 1'b0;
        ex_take_branch = 1'b0;
        ex_target_pc = '0;
        imem_bus.imem_req_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        id_stall_flag = 1'b0;
        ex_take_branch = 1'b0;
        ex_target_pc = '0;
        imem_bus.imem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks += 4;
            if (imem_bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", imem_bus.imem_req_valid); end
            if (if_id_valid_inst !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if_id_valid_inst); end
            if (if_id_IR !== 32'h0000_0013) begin errors++; $display("FAIL reset_ir: got %h expected 00000013", if_id_IR); end
            if (if_id_PC !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", if_id_PC); end
            step();
        end
        rst = 1'b0;
        @(negedge clk);
        checks += 2;
        if (imem_bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid: got %b expected 1", imem_bus.imem_req_valid); end
        if (imem_bus.imem_addr !== 32'h0) begin errors++; $display("FAIL first_req_addr: got %h expected 00000000", imem_bus.imem_addr); end
        step();
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc, exp_issue;
        int seen;
        do_reset();
        mem_lat = 1;
        exp_pc = 32'h0;
        exp_issue = 32'h0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (imem_bus.imem_req_valid && imem_bus.imem_req_ready) begin
                checks++;
                if (imem_bus.imem_addr !== exp_issue) begin errors++; $display("FAIL stream_addr: got %h expected %h", imem_bus.imem_addr, exp_issue); end
                exp_issue += 32'd4;
            end
            if (if_id_valid_inst) begin
                checks += 2;
                if (if_id_PC !== exp_pc) begin errors++; $display("FAIL stream_pc: got %h expected %h", if_id_PC, exp_pc); end
                if (if_id_IR !== instr_of(exp_pc)) begin errors++; $display("FAIL stream_ir: got %h expected %h", if_id_IR, instr_of(exp_pc)); end
                exp_pc += 32'd4;
                seen++;
            end
            step();
        end
        checks++;
        if (seen < 6) begin errors++; $display("FAIL stream_count: got %0d instructions expected at least 6", seen); end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc;
        int seen;
        do_reset();
        mem_lat = 1;
        id_stall_flag = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                checks += 3;
                if (if_id_valid_inst !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b expected 1", if_id_valid_inst); end
                if (if_id_PC !== 32'h0) begin errors++; $display("FAIL stall_head_pc: got %h expected 00000000", if_id_PC); end
                if (if_id_IR !== instr_of(32'h0)) begin errors++; $display("FAIL stall_head_ir: got %h expected %h", if_id_IR, instr_of(32'h0)); end
            end
            if (i >= 3) begin
                checks++;
                if (imem_bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_no_credit: req_valid got %b expected 0", imem_bus.imem_req_valid); end
            end
            step();
        end
        id_stall_flag = 1'b0;
        exp_pc = 32'h0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if_id_valid_inst) begin
                checks += 2;
                if (if_id_PC !== exp_pc) begin errors++; $display("FAIL stall_resume_pc: got %h expected %h", if_id_PC, exp_pc); end
                if (if_id_IR !== instr_of(exp_pc)) begin errors++; $display("FAIL stall_resume_ir: got %h expected %h", if_id_IR, instr_of(exp_pc)); end
                exp_pc += 32'd4;
                seen++;
            end
            step();
        end
        checks++;
        if (seen < 4) begin errors++; $display("FAIL stall_resume_count: got %0d expected at least 4", seen); end
    endtask

    task automatic test_redirect();
        logic [31:0] exp_pc;
        int n;
        bit issued;
        mem_lat = 3;
        imem_bus.imem_req_ready = 1'b0;
        repeat (6) step();
        imem_bus.imem_req_ready = 1'b1;
        step();
        step();
        ex_take_branch = 1'b1;
        ex_target_pc = 32'h0000_0100;
        @(negedge clk);
        checks++;
        if (imem_bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL redirect_no_issue: got %b expected 0", imem_bus.imem_req_valid); end
        step();
        ex_take_branch = 1'b0;
        exp_pc = 32'h0000_0100;
        n = 0;
        issued = 0;
        for (int i = 0; i < 20 && n < 2; i++) begin
            @(negedge clk);
            if (imem_bus.imem_req_valid && imem_bus.imem_req_ready && !issued) begin
                checks++;
                if (imem_bus.imem_addr !== 32'h0000_0100) begin errors++; $display("FAIL redirect_first_addr: got %h expected 00000100", imem_bus.imem_addr); end
                issued = 1;
            end
            if (if_id_valid_inst) begin
                checks += 2;
                if (if_id_PC !== exp_pc) begin errors++; $display("FAIL redirect_pc: got %h expected %h", if_id_PC, exp_pc); end
                if (if_id_IR !== instr_of(exp_pc)) begin errors++; $display("FAIL redirect_ir: got %h expected %h", if_id_IR, instr_of(exp_pc)); end
                exp_pc += 32'd4;
                n++;
            end
            step();
        end
        checks++;
        if (n != 2) begin errors++; $display("FAIL redirect_timeout: got %0d instructions expected 2", n); end
    endtask

    task automatic test_perf();
`ifdef FETCH_PERF_CNT_EN
        bit got;
        checks += 2;
        if (fetch_stall_cycles_out !== 32'd5) begin errors++; $display("FAIL perf_stall: got %0d expected 5", fetch_stall_cycles_out); end
        if (fetch_flush_count_out !== 32'd2) begin errors++; $display("FAIL perf_flush: got %0d expected 2", fetch_flush_count_out); end
        id_stall_flag = 1'b1;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (if_id_valid_inst) got = 1;
            else step();
        end
        checks++;
        if (!got) begin errors++; $display("FAIL perf_sat_setup: no valid instruction within 10 cycles"); end
        force dut.stall_cnt = 32'hFFFF_FFFE;
        step();
        release dut.stall_cnt;
        step();
        @(negedge clk);
        checks++;
        if (fetch_stall_cycles_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL perf_sat_reach: got %h expected ffffffff", fetch_stall_cycles_out); end
        step();
        step();
        @(negedge clk);
        checks++;
        if (fetch_stall_cycles_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL perf_sat_hold: got %h expected ffffffff", fetch_stall_cycles_out); end
        step();
        id_stall_flag = 1'b0;
`else
        checks += 2;
        if (fetch_stall_cycles_out !== 32'd0) begin errors++; $display("FAIL perf_stall_off: got %0d expected 0", fetch_stall_cycles_out); end
        if (fetch_flush_count_out !== 32'd0) begin errors++; $display("FAIL perf_flush_off: got %0d expected 0", fetch_flush_count_out); end
`endif
    endtask

    task automatic redirect_case(input logic [31:0] target, input bit with_stall,
                                 input bit ready_low, input bit at_rsp);
        logic [31:0] exp_pc;
        int n;
        bit hit;
        id_stall_flag = 1'b0;
        imem_bus.imem_req_ready = 1'b1;
        mem_lat = 1;
        repeat (4) step();
        if (ready_low) begin
            imem_bus.imem_req_ready = 1'b0;
            repeat (2) step();
        end
        if (at_rsp) begin
            hit = 0;
            for (int i = 0; i < 10 && !hit; i++) begin
                step();
                #1;
                if (imem_bus.imem_rsp_valid) hit = 1;
            end
            checks++;
            if (!hit) begin errors++; $display("FAIL corner_rsp_wait: no response within 10 cycles"); end
        end
        ex_take_branch = 1'b1;
        ex_target_pc = target;
        id_stall_flag = with_stall;
        @(negedge clk);
        checks++;
        if (imem_bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL corner_no_issue: got %b expected 0", imem_bus.imem_req_valid); end
        step();
        ex_take_branch = 1'b0;
        id_stall_flag = 1'b0;
        exp_pc = {target[31:2], 2'b00};
        if (ready_low) begin
            @(negedge clk);
            checks += 3;
            if (imem_bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL corner_hold_valid: got %b expected 1", imem_bus.imem_req_valid); end
            if (imem_bus.imem_addr !== exp_pc) begin errors++; $display("FAIL corner_hold_addr: got %h expected %h", imem_bus.imem_addr, exp_pc); end
            if (if_id_valid_inst !== 1'b0) begin errors++; $display("FAIL corner_flush_valid: got %b expected 0", if_id_valid_inst); end
            step();
            imem_bus.imem_req_ready = 1'b1;
        end
        n = 0;
        for (int i = 0; i < 20 && n < 3; i++) begin
            @(negedge clk);
            if (i == 0 && !ready_low) begin
                checks++;
                if (if_id_valid_inst !== 1'b0) begin errors++; $display("FAIL corner_flush_valid: got %b expected 0", if_id_valid_inst); end
            end
            if (if_id_valid_inst) begin
                checks += 2;
                if (if_id_PC !== exp_pc) begin errors++; $display("FAIL corner_pc: got %h expected %h", if_id_PC, exp_pc); end
                if (if_id_IR !== instr_of(exp_pc)) begin errors++; $display("FAIL corner_ir: got %h expected %h", if_id_IR, instr_of(exp_pc)); end
                exp_pc += 32'd4;
                n++;
            end
            step();
        end
        checks++;
        if (n != 3) begin errors++; $display("FAIL corner_timeout: got %0d instructions expected 3 after target %h", n, target); end
    endtask

    task automatic test_corners();
        redirect_case(32'h0000_0102, 1'b0, 1'b0, 1'b1);
        redirect_case(32'h0000_0200, 1'b1, 1'b0, 1'b0);
        redirect_case(32'h0000_030E, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        imem_bus.imem_req_ready = 1'b1;
        test_reset();
        test_stream();
        do_reset();
        test_stall();
        test_redirect();
        test_perf();
        test_corners();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
